// File: rtl/dram_cache_tag_ctrl_if.sv
// Bundle of the upstream request/response handshake and the AXI-style DRAM
// channels used by dram_cache_tag_ctrl. The controller connects through the
// slave modport (it serves upstream requests); the environment uses master.
interface dram_cache_tag_ctrl_if #(
    parameter int ID_W = 16
);
    // Upstream request
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_write_i;
    logic [63:0]      req_addr_i;
    logic [511:0]     req_wdata_i;

    // Upstream response
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_write_o;
    logic             rsp_hit_o;
    logic             rsp_dirty_o;
    logic [511:0]     rsp_data_o;
    logic [31:0]      rsp_tag_o;

    // AR / R channels
    logic [ID_W-1:0]  arid_o;
    logic [63:0]      araddr_o;
    logic             arvalid_o;
    logic             arready_i;
    logic [ID_W-1:0]  rid_i;
    logic [575:0]     rdata_i;
    logic             rvalid_i;
    logic             rready_o;

    // AW / W / B channels
    logic [ID_W-1:0]  awid_o;
    logic [63:0]      awaddr_o;
    logic             awvalid_o;
    logic             awready_i;
    logic [ID_W-1:0]  wid_o;
    logic [511:0]     wdata_o;
    logic             wvalid_o;
    logic             wready_i;
    logic [ID_W-1:0]  bid_i;
    logic             bvalid_i;
    logic             bready_o;

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output rsp_valid_o, rsp_write_o, rsp_hit_o, rsp_dirty_o, rsp_data_o, rsp_tag_o,
        input  rsp_ready_i,
        output arid_o, araddr_o, arvalid_o,
        input  arready_i,
        input  rid_i, rdata_i, rvalid_i,
        output rready_o,
        output awid_o, awaddr_o, awvalid_o, wid_o, wdata_o, wvalid_o,
        input  awready_i, wready_i,
        input  bid_i, bvalid_i,
        output bready_o
    );

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_write_o, rsp_hit_o, rsp_dirty_o, rsp_data_o, rsp_tag_o,
        output rsp_ready_i,
        input  arid_o, araddr_o, arvalid_o,
        output arready_i,
        output rid_i, rdata_i, rvalid_i,
        input  rready_o,
        input  awid_o, awaddr_o, awvalid_o, wid_o, wdata_o, wvalid_o,
        output awready_i, wready_i,
        output bid_i, bvalid_i,
        input  bready_o
    );
endinterface

// File: rtl/dram_cache_tag_ctrl.sv
// DRAM cache tag controller: serves one lookup or line fill at a time.
// A lookup reads the tag word + line over AR/R and reports hit/dirty/tag;
// a fill writes the line over AW/W and waits for B.
// Optional lookup hit/miss counters are built when DRAM_CACHE_HITCNT_EN is
// defined; otherwise the counter ports are tied to zero.
module dram_cache_tag_ctrl #(
    parameter int ID_W   = 16,
    parameter int AXI_ID = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_cache_tag_ctrl_if.slave bus,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AWW,
        B,
        RSP
    } state_t;

    state_t       state;

    logic         req_ready;
    logic         arvalid;
    logic         rready;
    logic         awvalid;
    logic         wvalid;
    logic         bready;
    logic         rsp_valid;
    logic         rsp_write;
    logic         rsp_hit;
    logic         rsp_dirty;
    logic [511:0] rsp_data;
    logic [31:0]  rsp_tag;
    logic [63:0]  addr_q;
    logic [511:0] wdata_q;

    // Tag word decode of the returned line: [63] valid, [62] dirty, [61:30] tag
    logic         rd_valid;
    logic         rd_dirty;
    logic [31:0]  rd_tag;
    logic         rd_hit;
    logic         aw_done;
    logic         w_done;
    logic         unused_bits;

    assign rd_valid = bus.rdata_i[575];
    assign rd_dirty = bus.rdata_i[574];
    assign rd_tag   = bus.rdata_i[573:542];
    assign rd_hit   = rd_valid && (rd_tag == addr_q[63:32]);

    // A channel counts as done once its valid has dropped or it handshakes now
    assign aw_done  = !awvalid || bus.awready_i;
    assign w_done   = !wvalid  || bus.wready_i;

    // IDs are ignored, as are the tag word's low bits and the byte offset
    assign unused_bits = ^{bus.rid_i, bus.bid_i, bus.rdata_i[541:512], bus.req_addr_i[5:0]};

    assign bus.req_ready_o = req_ready;
    assign bus.arid_o      = ID_W'(AXI_ID);
    assign bus.awid_o      = ID_W'(AXI_ID);
    assign bus.wid_o       = ID_W'(AXI_ID);
    assign bus.araddr_o    = addr_q;
    assign bus.awaddr_o    = addr_q;
    assign bus.wdata_o     = wdata_q;
    assign bus.arvalid_o   = arvalid;
    assign bus.rready_o    = rready;
    assign bus.awvalid_o   = awvalid;
    assign bus.wvalid_o    = wvalid;
    assign bus.bready_o    = bready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_write_o = rsp_write;
    assign bus.rsp_hit_o   = rsp_hit;
    assign bus.rsp_dirty_o = rsp_dirty;
    assign bus.rsp_data_o  = rsp_data;
    assign bus.rsp_tag_o   = rsp_tag;

    // Transaction FSM with all handshake outputs and response fields registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_dirty <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (bus.req_valid_i && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= {bus.req_addr_i[63:6], 6'b0};
                        wdata_q   <= bus.req_wdata_i;
                        if (bus.req_write_i) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= AWW;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
                    end
                end
                AR: begin
                    if (bus.arready_i) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (bus.rvalid_i) begin
                        rready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        rsp_hit   <= rd_hit;
                        rsp_dirty <= rd_dirty;
                        rsp_tag   <= rd_tag;
                        rsp_data  <= bus.rdata_i[511:0];
                        state     <= RSP;
                    end
                end
                AWW: begin
                    if (bus.awready_i) begin
                        awvalid <= 1'b0;
                    end
                    if (bus.wready_i) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bus.bvalid_i) begin
                        bready    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_dirty <= 1'b0;
                        rsp_tag   <= addr_q[63:32];
                        rsp_data  <= '0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DRAM_CACHE_HITCNT_EN
    logic        rd_rsp_fire;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    assign rd_rsp_fire = rsp_valid && bus.rsp_ready_i && !rsp_write;

    // Saturating lookup statistics, bumped when a read response is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rd_rsp_fire) begin
            if (rsp_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dram_cache_tag_ctrl.sv
// Self-checking bench for dram_cache_tag_ctrl. The bench plays the DRAM side
// with a per-index line store (valid, dirty, tag, data) and predicts each
// response from that store. Build with DRAM_CACHE_HITCNT_EN to exercise the
// hit/miss counters.
module tb_dram_cache_tag_ctrl;

    localparam int ID_W = 16;
`ifdef DRAM_CACHE_HITCNT_EN
    localparam bit HITCNT_EN = 1'b1;
`else
    localparam bit HITCNT_EN = 1'b0;
`endif

    typedef struct packed {
        bit         valid;
        bit         dirty;
        bit [31:0]  tag;
        bit [511:0] data;
    } line_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    line_t       mem [bit [25:0]];
    int unsigned model_hits   = 0;
    int unsigned model_misses = 0;
    int          n_checks     = 0;
    int          n_fail       = 0;
    int          ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;

    dram_cache_tag_ctrl_if #(.ID_W(ID_W)) bus ();

    dram_cache_tag_ctrl #(.ID_W(ID_W), .AXI_ID(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    always #5 clk = ~clk;

    // Count every channel handshake seen on a rising edge
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.arvalid_o && bus.arready_i) ar_hs <= ar_hs + 1;
            if (bus.rready_o  && bus.rvalid_i)  r_hs  <= r_hs + 1;
            if (bus.awvalid_o && bus.awready_i) aw_hs <= aw_hs + 1;
            if (bus.wvalid_o  && bus.wready_i)  w_hs  <= w_hs + 1;
            if (bus.bready_o  && bus.bvalid_i)  b_hs  <= b_hs + 1;
        end
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Lines never filled hold arbitrary content, fixed on first touch
    function automatic line_t get_line(input bit [25:0] idx);
        line_t ln;
        if (!mem.exists(idx)) begin
            ln.valid = 1'($urandom_range(0, 1));
            ln.dirty = 1'($urandom_range(0, 1));
            ln.tag   = 32'($urandom_range(0, 3));
            ln.data  = rand512();
            mem[idx] = ln;
        end
        return mem[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [575:0] obs, input logic [575:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Present one upstream request and let it be accepted on the next edge
    task automatic applyStimulus(input bit write, input logic [63:0] addr, input logic [511:0] data);
        int k = 0;
        while (!bus.req_ready_o && k < 50) begin
            tick();
            k++;
        end
        checkOutput("req_ready_wait", 576'(bus.req_ready_o), 576'(1));
        bus.req_valid_i = 1'b1;
        bus.req_write_i = write;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = data;
        tick();
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = {$urandom, $urandom};
        bus.req_wdata_i = rand512();
    endtask

    task automatic do_read(input logic [63:0] addr, input int hold);
        line_t       ln;
        bit          exp_hit;
        logic [63:0] exp_araddr;
        int          ar0, r0;
        ln         = get_line(addr[31:6]);
        exp_hit    = ln.valid && (ln.tag == addr[63:32]);
        exp_araddr = {addr[63:6], 6'b0};
        ar0        = ar_hs;
        r0         = r_hs;
        applyStimulus(1'b0, addr, rand512());
        checkOutput("arvalid_n1", 576'(bus.arvalid_o), 576'(1));
        checkOutput("araddr", 576'(bus.araddr_o), 576'(exp_araddr));
        checkOutput("arid", 576'(bus.arid_o), 576'(1));
        checkOutput("req_ready_busy", 576'(bus.req_ready_o), 576'(0));
        repeat ($urandom_range(0, 3)) begin
            bus.rvalid_i = 1'($urandom_range(0, 1));
            bus.bvalid_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.rvalid_i = 1'b0;
        bus.bvalid_i = 1'b0;
        checkOutput("ar_hold", 576'({bus.arvalid_o, bus.araddr_o}), 576'({1'b1, exp_araddr}));
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        checkOutput("ar_done", 576'({bus.arvalid_o, bus.rready_o}), 576'({1'b0, 1'b1}));
        repeat ($urandom_range(0, 3)) begin
            bus.arready_i = 1'($urandom_range(0, 1));
            tick();
        end
        bus.arready_i = 1'b0;
        bus.rid_i     = ID_W'($urandom);
        bus.rdata_i   = {ln.valid, ln.dirty, ln.tag, 30'($urandom), ln.data};
        bus.rvalid_i  = 1'b1;
        tick();
        bus.rvalid_i  = 1'b0;
        checkOutput("rsp_valid_rd", 576'(bus.rsp_valid_o), 576'(1));
        checkOutput("rsp_write_rd", 576'(bus.rsp_write_o), 576'(0));
        checkOutput("rsp_hit", 576'(bus.rsp_hit_o), 576'(exp_hit));
        checkOutput("rsp_dirty", 576'(bus.rsp_dirty_o), 576'(ln.dirty));
        checkOutput("rsp_tag", 576'(bus.rsp_tag_o), 576'(ln.tag));
        checkOutput("rsp_data", 576'(bus.rsp_data_o), 576'(ln.data));
        repeat (hold) tick();
        checkOutput("rsp_hold_rd",
            576'({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_hit_o, bus.rsp_dirty_o, bus.rsp_tag_o, bus.rsp_data_o}),
            576'({1'b1, 1'b0, exp_hit, ln.dirty, ln.tag, ln.data}));
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        checkOutput("rsp_release_rd", 576'({bus.rsp_valid_o, bus.req_ready_o}), 576'({1'b0, 1'b1}));
        checkOutput("rd_handshakes", 576'({ar_hs - ar0, r_hs - r0}), 576'({32'd1, 32'd1}));
        if (exp_hit) model_hits++;
        else         model_misses++;
    endtask

    // mode 0: AW and W together; 1: AW then W three cycles later; 2: W then AW
    task automatic do_write(input logic [63:0] addr, input logic [511:0] data, input int mode, input int hold);
        line_t ln;
        int    aw0, w0, b0;
        aw0 = aw_hs;
        w0  = w_hs;
        b0  = b_hs;
        applyStimulus(1'b1, addr, data);
        checkOutput("aww_valid_n1", 576'({bus.awvalid_o, bus.wvalid_o}), 576'({1'b1, 1'b1}));
        checkOutput("awaddr", 576'(bus.awaddr_o), 576'({addr[63:6], 6'b0}));
        checkOutput("wdata", 576'(bus.wdata_o), 576'(data));
        checkOutput("aw_w_id", 576'({bus.awid_o, bus.wid_o}), 576'({16'd1, 16'd1}));
        repeat ($urandom_range(0, 2)) tick();
        if (mode == 0) begin
            bus.awready_i = 1'b1;
            bus.wready_i  = 1'b1;
            tick();
        end else if (mode == 1) begin
            bus.awready_i = 1'b1;
            tick();
            bus.awready_i = 1'b0;
            checkOutput("aw_first", 576'({bus.awvalid_o, bus.wvalid_o, bus.bready_o}), 576'({1'b0, 1'b1, 1'b0}));
            bus.awready_i = 1'b1;
            tick();
            tick();
            bus.awready_i = 1'b0;
            bus.wready_i  = 1'b1;
            tick();
        end else begin
            bus.wready_i = 1'b1;
            tick();
            bus.wready_i = 1'b0;
            checkOutput("w_first", 576'({bus.awvalid_o, bus.wvalid_o, bus.bready_o}), 576'({1'b1, 1'b0, 1'b0}));
            bus.wready_i = 1'b1;
            tick();
            tick();
            bus.wready_i  = 1'b0;
            bus.awready_i = 1'b1;
            tick();
        end
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b0;
        checkOutput("aww_done", 576'({bus.awvalid_o, bus.wvalid_o, bus.bready_o}), 576'({1'b0, 1'b0, 1'b1}));
        repeat ($urandom_range(0, 3)) tick();
        bus.bid_i    = ID_W'($urandom);
        bus.bvalid_i = 1'b1;
        tick();
        bus.bvalid_i = 1'b0;
        checkOutput("rsp_wr",
            576'({bus.rsp_valid_o, bus.rsp_write_o, bus.rsp_hit_o, bus.rsp_dirty_o, bus.rsp_tag_o, bus.rsp_data_o}),
            576'({1'b1, 1'b1, 1'b1, 1'b0, addr[63:32], 512'd0}));
        repeat (hold) tick();
        checkOutput("rsp_hold_wr", 576'({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_tag_o}), 576'({1'b1, 1'b0, addr[63:32]}));
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        checkOutput("rsp_release_wr", 576'({bus.rsp_valid_o, bus.req_ready_o}), 576'({1'b0, 1'b1}));
        checkOutput("wr_handshakes", 576'({aw_hs - aw0, w_hs - w0, b_hs - b0}), 576'({32'd1, 32'd1, 32'd1}));
        ln.valid = 1'b1;
        ln.dirty = 1'b0;
        ln.tag   = addr[63:32];
        ln.data  = data;
        mem[addr[31:6]] = ln;
    endtask

    task automatic check_counters(input string name);
        checkOutput({name, "_hit_cnt"}, 576'(hit_cnt), 576'(HITCNT_EN ? model_hits : 0));
        checkOutput({name, "_miss_cnt"}, 576'(miss_cnt), 576'(HITCNT_EN ? model_misses : 0));
    endtask

    initial begin
        logic [63:0] a;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.arready_i   = 1'b0;
        bus.rid_i       = '0;
        bus.rdata_i     = '0;
        bus.rvalid_i    = 1'b0;
        bus.awready_i   = 1'b0;
        bus.wready_i    = 1'b0;
        bus.bid_i       = '0;
        bus.bvalid_i    = 1'b0;

        $display("[TB] reset");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs",
            576'({bus.req_ready_o, bus.arvalid_o, bus.rready_o, bus.awvalid_o, bus.wvalid_o, bus.bready_o, bus.rsp_valid_o}),
            576'(0));
        checkOutput("reset_rsp", 576'({bus.rsp_write_o, bus.rsp_hit_o, bus.rsp_dirty_o, bus.rsp_tag_o, bus.rsp_data_o}), 576'(0));
        checkOutput("reset_addr", 576'({bus.araddr_o, bus.awaddr_o}), 576'(0));
        checkOutput("reset_counters", 576'({hit_cnt, miss_cnt}), 576'(0));
        tick();
        tick();
        checkOutput("req_ready_in_reset", 576'(bus.req_ready_o), 576'(0));
        rst_n = 1'b1;
        tick();
        checkOutput("req_ready_after_reset", 576'(bus.req_ready_o), 576'(1));

        $display("[TB] fill then hit, miss, hit");
        do_write(64'h0000_0001_0000_0040, {64{8'hA5}}, 0, 0);
        do_read(64'h0000_0001_0000_0040, 5);
        checkOutput("req032_hit", 576'({bus.rsp_hit_o, bus.rsp_dirty_o, bus.rsp_tag_o, bus.rsp_data_o}),
            576'({1'b1, 1'b0, 32'h0000_0001, {64{8'hA5}}}));
        do_read(64'h0000_0002_0000_0040, 1);
        checkOutput("req033_victim", 576'({bus.rsp_hit_o, bus.rsp_tag_o}), 576'({1'b0, 32'h0000_0001}));
        do_read(64'h0000_0001_0000_0040, 0);
        checkOutput("seq_hit_cnt", 576'(hit_cnt), 576'(HITCNT_EN ? 32'd2 : 32'd0));
        checkOutput("seq_miss_cnt", 576'(miss_cnt), 576'(HITCNT_EN ? 32'd1 : 32'd0));

        $display("[TB] offset masking and split AW/W handshakes");
        do_read(64'h0000_0005_0000_1047, 2);
        do_write(64'h0000_0003_0000_0085, rand512(), 1, 1);
        do_write(64'h0000_0004_0000_00C0, rand512(), 2, 0);
        do_read(64'h0000_0003_0000_0080, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            a = {32'($urandom_range(1, 3)), 20'h0, 6'($urandom_range(4, 7)), 6'($urandom)};
            if ($urandom_range(0, 9) < 4)
                do_write(a, rand512(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 3)));
        end
        check_counters("random");

        $display("[TB] reset during AR");
        applyStimulus(1'b0, 64'h0000_0001_0000_0040, rand512());
        checkOutput("ar_before_reset", 576'(bus.arvalid_o), 576'(1));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("ar_async_clear", 576'({bus.arvalid_o, bus.rready_o, bus.req_ready_o}), 576'(0));
        bus.arready_i = 1'b1;
        bus.rvalid_i  = 1'b1;
        repeat (3) tick();
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b0;
        checkOutput("no_rsp_in_reset", 576'(bus.rsp_valid_o), 576'(0));
        rst_n = 1'b1;
        model_hits   = 0;
        model_misses = 0;
        tick();
        checkOutput("idle_after_reset", 576'({bus.req_ready_o, bus.rsp_valid_o, bus.arvalid_o}), 576'({1'b1, 1'b0, 1'b0}));
        check_counters("post_reset");
        do_read(64'h0000_0001_0000_0040, 1);
        check_counters("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_cache_tag_ctrl.md
DRAM_CACHE_TAG_CTRL -- requirements
Module: dram_cache_tag_ctrl

Interface
REQ-001 SHALL have parameter ID_W, default 16, AXI ID width.
REQ-002 SHALL have parameter AXI_ID, default 1, constant driven on arid_o/awid_o/wid_o.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i / req_ready_o  input/output  1/1  upstream request handshake.
REQ-006 SHALL have port req_write_i  input  1  1=line fill (write), 0=lookup (read).
REQ-007 SHALL have port req_addr_i  input  64  byte address; tag=[63:32], index=[31:6], offset=[5:0] ignored.
REQ-008 SHALL have port req_wdata_i  input  512  fill data.
REQ-009 SHALL have port rsp_valid_o / rsp_ready_i  output/input  1/1  response handshake.
REQ-010 SHALL have port rsp_write_o, rsp_hit_o, rsp_dirty_o  output  1 each  echo of req_write, hit flag, stored dirty bit.
REQ-011 SHALL have port rsp_data_o  output  512  line data read; 0 for writes.
REQ-012 SHALL have port rsp_tag_o  output  32  stored tag field (victim tag on miss).
REQ-013 SHALL have AR channel arid_o(ID_W), araddr_o(64), arvalid_o out; arready_i in.
REQ-014 SHALL have R channel rid_i(ID_W), rdata_i(576: [575:512] tag word, [511:0] data), rvalid_i in; rready_o out.
REQ-015 SHALL have AW/W channels awid_o, awaddr_o(64), awvalid_o, wid_o, wdata_o(512), wvalid_o out; awready_i, wready_i in.
REQ-016 SHALL have B channel bid_i(ID_W), bvalid_i in; bready_o out.
REQ-017 SHALL have port hit_cnt_o / miss_cnt_o  output  32/32  lookup statistics (see Configuration).

Function
REQ-018 SHALL have states IDLE, AR, R, AWW, B, RSP; one transaction outstanding.
REQ-019 IDLE: req_ready_o=1; on req_valid_i&req_ready_o register addr with [5:0] forced 0, write flag, wdata; next AR (read) or AWW (write).
REQ-020 AR: arvalid_o=1, araddr_o stable; on arready_i go R next cycle.
REQ-021 R: rready_o=1; on rvalid_i register rdata_i, go RSP; rid_i ignored.
REQ-022 Hit SHALL be tagword[63] (valid) AND tagword[61:30]==addr[63:32]; rsp_dirty_o=tagword[62]; rsp_tag_o=tagword[61:30].
REQ-023 AWW: awvalid_o and wvalid_o both asserted from entry; each drops independently after its own handshake; go B when both done, including same-cycle completion.
REQ-024 B: bready_o=1; on bvalid_i go RSP with rsp_write_o=1, rsp_hit_o=1, rsp_dirty_o=0, rsp_tag_o=addr[63:32], rsp_data_o=0.
REQ-025 RSP: rsp_valid_o=1, all rsp_* fields registered and stable until rsp_ready_i; then IDLE (next request accepted one cycle later).
REQ-026 Request accepted in cycle N SHALL present arvalid_o/awvalid_o in cycle N+1.
REQ-027 rvalid_i/bvalid_i/ready inputs outside their state SHALL be ignored; valid outputs SHALL never drop before handshake.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, all *valid_o, *ready_o, rsp_* , address/data registers and counters to 0; req_ready_o=1 only after rst_n deasserts.
REQ-029 Reset mid-transaction SHALL abandon it with no response.

Configuration
REQ-030 With DRAM_CACHE_HITCNT_EN defined, hit_cnt_o/miss_cnt_o SHALL increment (saturating at 0xFFFF_FFFF) on each read response handshake by hit/miss; writes not counted.
REQ-031 Without DRAM_CACHE_HITCNT_EN, both ports SHALL be tied to 0 and no counter flops exist.

Verification
REQ-032 Write addr 0x0000_0001_0000_0040, data 0xA5 pattern, then read same addr -> rsp_hit_o=1, rsp_dirty_o=0, rsp_tag_o=0x0000_0001, rsp_data_o=0xA5 pattern.
REQ-033 Then read 0x0000_0002_0000_0040 -> rsp_hit_o=0, rsp_tag_o=0x0000_0001 (victim).
REQ-034 Read 0x...0047 (offset 7) -> araddr_o=0x...0040.
REQ-035 Slave raising awready_i and wready_i same cycle, then separately 3 cycles apart -> exactly one AW and one W handshake each, one B.
REQ-036 Hold rsp_ready_i low 5 cycles -> rsp_* stable, req_ready_o=0; rst_n low during AR -> arvalid_o=0 at once, no rsp_valid_o.
REQ-037 With DRAM_CACHE_HITCNT_EN, sequence hit,miss,hit -> hit_cnt_o=2, miss_cnt_o=1; without it both read 0.
